// File: rtl/mem_stage.sv
// Memory pipeline stage: sits downstream of execute and holds one instruction.
// Loads and stores go out over a req/ack data-memory handshake. Misaligned
// half/word accesses raise a one-cycle address exception and are dropped.
// The finished instruction is presented on the memory-to-writeback bus.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   EXE_MEM_BUS, in_valid  incoming {through[15:0], alu_data, out_data, pc[29:0]}
//   ready                 stage can capture this cycle (execute's next_valid)
//   dm_*                  data-memory request/response interface
//   MEM_WB_BUS, out_valid outgoing {reg_we, rd[4:0], result[31:0], pc[29:0]}
//   next_valid            writeback accepts this cycle
//   adex, badvaddr, epc   misaligned-access exception pulse and its details
module mem_stage #(
    parameter int unsigned ADDR_ALIGN_CHECK = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [109:0] EXE_MEM_BUS,
    input  logic         in_valid,
    output logic         ready,
    output logic         dm_req,
    output logic         dm_we,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_be,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ack,
    output logic [67:0]  MEM_WB_BUS,
    output logic         out_valid,
    input  logic         next_valid,
    output logic         adex,
    output logic [31:0]  badvaddr,
    output logic [31:0]  epc
);

    typedef enum logic [1:0] {StIdle, StAccess, StHold, StFault} state_e;

    state_e         state_q, state_d;
    logic [109:0]   ent_q, ent_d;
    logic [31:0]    rdata_q, rdata_d;

    // Where a freshly captured entry goes first.
    function automatic state_e target_state(input logic [109:0] bus);
        logic       is_mem;
        logic       misal;
        logic [1:0] sz;
        logic [1:0] a;
        is_mem = bus[109] | bus[108];
        sz     = bus[107:106];
        a      = bus[63:62];
        misal  = ((sz == 2'b01) & a[0]) | (sz[1] & (a != 2'b00));
        if (!is_mem) begin
            return StHold;
        end else if (misal && (ADDR_ALIGN_CHECK != 0)) begin
            return StFault;
        end else begin
            return StAccess;
        end
    endfunction

    // Stored entry fields
    logic [15:0] thr;
    logic [31:0] alu;
    logic [31:0] od;
    logic [29:0] pc;
    logic [1:0]  a;
    logic        is_store;
    logic        is_load;

    assign thr      = ent_q[109:94];
    assign alu      = ent_q[93:62];
    assign od       = ent_q[61:30];
    assign pc       = ent_q[29:0];
    assign a        = alu[1:0];
    assign is_store = thr[14];
    assign is_load  = thr[15] & ~thr[14];

    logic unused_reserved;
    assign unused_reserved = ^thr[4:0];

    logic capture;

    always_comb begin
        ready   = (state_q == StIdle) | ((state_q == StHold) & next_valid);
        capture = in_valid & ready;
        state_d = state_q;
        ent_d   = ent_q;
        rdata_d = rdata_q;
        if (capture) begin
            // Covers both IDLE and the HOLD pass-through case.
            ent_d   = EXE_MEM_BUS;
            state_d = target_state(EXE_MEM_BUS);
        end else begin
            unique case (state_q)
                StIdle:   state_d = StIdle;
                StAccess: begin
                    if (dm_ack) begin
                        rdata_d = dm_rdata;
                        state_d = StHold;
                    end
                end
                StHold:   if (next_valid) state_d = StIdle;
                StFault:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ent_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane formatting
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] result;
    logic        reg_we_out;

    always_comb begin
        unique case (thr[13:12])
            2'b00: begin
                lane_be    = 4'b0001 << a;
                lane_wdata = {4{od[7:0]}};
            end
            2'b01: begin
                lane_be    = a[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{od[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = od;
            end
        endcase

        rd_shift = rdata_q >> {a, 3'b000};
        ld_byte  = rd_shift[7:0];
        ld_half  = a[1] ? rdata_q[31:16] : rdata_q[15:0];
        unique case (thr[13:12])
            2'b00:   ld_data = {{24{thr[11] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{thr[11] & ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase

        result     = is_load ? ld_data : od;
        reg_we_out = thr[10] & ~is_store;
    end

    always_comb begin
        dm_req     = (state_q == StAccess);
        dm_we      = dm_req & is_store;
        dm_addr    = dm_req ? alu : '0;
        dm_be      = dm_req ? lane_be : '0;
        dm_wdata   = dm_req ? lane_wdata : '0;
        out_valid  = (state_q == StHold);
        MEM_WB_BUS = out_valid ? {reg_we_out, thr[9:5], result, pc} : '0;
        adex       = (state_q == StFault);
        badvaddr   = adex ? alu : '0;
        epc        = adex ? {pc, 2'b00} : '0;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the 110-bit execute-to-memory bus.
- Performs any data-memory load or store over a req/ack handshake, then forms the 68-bit memory-to-writeback bus.
- Holds one instruction, and uses the same valid/next_valid handshake style as the execute stage.

Parameters:
- ADDR_ALIGN_CHECK, 1, when 1 misaligned half/word accesses raise an address exception instead of accessing memory.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- EXE_MEM_BUS  input  110  {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}
- in_valid  input  1  execute stage has a finished instruction on EXE_MEM_BUS
- ready  output  1  stage can capture EXE_MEM_BUS this cycle; fed back as execute's next_valid
- dm_req  output  1  data-memory request
- dm_we  output  1  1 = store
- dm_addr  output  32  byte address (= alu_data)
- dm_be  output  4  byte enables
- dm_wdata  output  32  store data, lane-replicated
- dm_rdata  input  32  load data, valid with dm_ack
- dm_ack  input  1  one-cycle completion pulse
- MEM_WB_BUS  output  68  {reg_we, rd[4:0], result[31:0], pc[29:0]}
- out_valid  output  1  MEM_WB_BUS holds a valid instruction
- next_valid  input  1  writeback accepts this cycle
- adex  output  1  one-cycle pulse on a misaligned access
- badvaddr  output  32  faulting address, valid with adex
- epc  output  32  {pc, 2'b00} of the faulting instruction, valid with adex

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset.
- Reset values:
  - All outputs 0 except ready = 1.
  - FSM goes to IDLE.
  - The stored entry is dropped.
- Reset mid-access: dm_req deasserts on the cycle after reset. A late dm_ack arriving while IDLE is ignored.
- through field decode:
  - [15] mem_rd, [14] mem_wr (if both are set, treat as store).
  - [13:12] size: 00 byte, 01 half, 10 and 11 word.
  - [11] sign-extend loads.
  - [10] reg_we, [9:5] rd.
  - [4:0] reserved, ignored.
- Capture: the entry is registered when in_valid & ready.
- ready = (state==IDLE) | (state==HOLD & next_valid). A pass-through allows back-to-back instructions at 1 per cycle.
- FSM states:
  - IDLE: on capture, go to HOLD if the op is not a memory op; go to ACCESS if it is a memory op and aligned; go to FAULT if misaligned.
  - ACCESS:
    - dm_req = 1 and dm_we/dm_addr/dm_be/dm_wdata are stable until dm_ack.
    - On dm_ack: latch load data and go to HOLD.
    - dm_req drops in the cycle after the ack.
  - HOLD:
    - out_valid = 1 and MEM_WB_BUS is stable.
    - If next_valid is 1: leave (to IDLE, or directly into the next entry's state if capturing). Otherwise stay.
  - FAULT: held 1 cycle. adex = 1, badvaddr/epc driven, entry discarded, out_valid = 0, ready = 0; next state IDLE.
- Latency:
  - Non-memory op captured at cycle N: out_valid at N+1.
  - Memory op captured at N: dm_req at N+1; if ack arrives at cycle M, out_valid at M+1.
  - Minimum memory-op latency is 2 cycles (ack at N+1).
- Byte lanes (little-endian, a = alu_data[1:0]):
  - Byte: dm_be = 4'b0001<<a, dm_wdata = {4{out_data[7:0]}}.
  - Half: dm_be = a[1] ? 4'b1100 : 4'b0011, dm_wdata = {2{out_data[15:0]}}.
  - Word: dm_be = 4'b1111, dm_wdata = out_data.
  - dm_addr = alu_data, unmodified.
- Alignment: half with a[0]=1, or word with a != 0, is misaligned when ADDR_ALIGN_CHECK=1. When ADDR_ALIGN_CHECK=0, the access proceeds as issued.
- Result:
  - Load: the selected byte/half of dm_rdata, zero- or sign-extended per [11]; word load passes dm_rdata.
  - Store: reg_we is forced to 0 on the output; result = out_data.
  - Other ops: result = out_data.
  - pc passes through unchanged.
- Outputs when not in HOLD: MEM_WB_BUS = 0 (NOP).
- Ack-cycle back-pressure: if dm_ack and next_valid=0 in the same cycle, the data is still latched and the stage waits in HOLD.

Test Plan:
- ALU pass-through: through=0x0400|rd 3<<5, out_data=0x1234_5678, captured at N → out_valid at N+1 with result 0x1234_5678, reg_we=1, rd=3, no dm_req.
- Sign-extended byte load: alu_data=0x0000_1003, size=00, sign=1, dm_rdata=0x80FF_0000, ack 2 cycles after req → dm_be=4'b1000, result=0xFFFF_FF80.
- Half store: alu_data=0x0000_2002, out_data=0xAAAA_BEEF → dm_we=1, dm_be=4'b1100, dm_wdata=0xBEEF_BEEF; output reg_we=0.
- Misaligned word load: alu_data=0x0000_0006, pc=0x100 → adex pulses 1 cycle, badvaddr=0x6, epc=0x400; no dm_req, out_valid stays 0.
- Back-pressure and streaming:
  - next_valid held 0 for 3 cycles with an entry in HOLD → MEM_WB_BUS stable and ready=0.
  - Then next_valid=1 with in_valid=1 → new entry captured the same cycle.
- Reset during ACCESS: dm_req=1 and reset asserted → dm_req=0 and out_valid=0 next cycle; a following dm_ack produces no output.
